// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the decoder and the EX unit,
// the multiply sequencing states, and the default datapath width.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    MUL_BUSY,
    MUL_DONE
  } aluState_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// Produces the low XLEN bits of a_i*b_i; done_o pulses on the final iteration.
module mul_iter
  import alu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int ITER = XLEN / MUL_STEP;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            running_q, running_d;
  logic [XLEN-1:0] partial;

  // Low-order result bits only, so the product wraps naturally mod 2^XLEN.
  assign partial = mcand_q * {{(XLEN-MUL_STEP){1'b0}}, mplier_q[MUL_STEP-1:0]};

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    running_d = running_q;
    if (abort) begin
      acc_d     = '0;
      count_d   = '0;
      running_d = 1'b0;
    end else if (start) begin
      mcand_d   = a_i;
      mplier_d  = b_i;
      acc_d     = '0;
      count_d   = '0;
      running_d = 1'b1;
    end else if (running_q) begin
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << MUL_STEP;
      mplier_d = mplier_q >> MUL_STEP;
      count_d  = count_q + CW'(1);
      if (count_q == LAST) begin
        running_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      running_q <= running_d;
    end
  end

  assign done_o    = running_q && (count_q == LAST);
  assign product_o = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle combinational ops plus a multi-cycle multiply
// that stalls the front end until its product is available.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            flush,
  input  logic            hold,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic            stall
);

  localparam int SHW = $clog2(XLEN);

  aluState_e       state_q, state_d;
  logic [XLEN-1:0] aluComb;
  logic [XLEN-1:0] product;
  logic [SHW-1:0]  shamt;
  logic            isMul, mulStart, mulDone;

  assign shamt    = SrcB[SHW-1:0];
  assign isMul    = (ALUControl == ALU_MUL);
  assign mulStart = (state_q == IDLE) && isMul && en && !flush;

  always_comb begin
    aluComb = '0;
    case (ALUControl)
      ALU_ADD:  aluComb = SrcA + SrcB;
      ALU_SUB:  aluComb = SrcA - SrcB;
      ALU_AND:  aluComb = SrcA & SrcB;
      ALU_OR:   aluComb = SrcA | SrcB;
      ALU_XOR:  aluComb = SrcA ^ SrcB;
      ALU_SLT:  aluComb = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLL:  aluComb = SrcA << shamt;
      ALU_SRL:  aluComb = SrcA >> shamt;
      ALU_SRA:  aluComb = $signed(SrcA) >>> shamt;
      ALU_SLTU: aluComb = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
      default:  aluComb = '0;
    endcase
  end

  mul_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) uMulIter (
    .clk       (clk),
    .reset     (reset),
    .start     (mulStart),
    .abort     (flush),
    .a_i       (SrcA),
    .b_i       (SrcB),
    .done_o    (mulDone),
    .product_o (product)
  );

  // Flush outranks every transition so an aborted multiply never completes.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (mulStart) state_d = MUL_BUSY;
        MUL_BUSY: if (mulDone)  state_d = MUL_DONE;
        MUL_DONE: if (!hold)    state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stall is combinational so the hazard unit sees it in the issuing cycle.
  always_comb begin
    ALUResult = aluComb;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        if (isMul) begin
          ALUResult = '0;
          stall     = en && !flush;
        end
      end
      MUL_BUSY: begin
        ALUResult = '0;
        stall     = !flush;
      end
      MUL_DONE: begin
        ALUResult = product;
      end
      default: begin
        ALUResult = '0;
      end
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors, multiply timing and
// abort sequences on MUL_STEP=1 and MUL_STEP=4 instances, then random ops.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, en4, flush, hold;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA, SrcB;
  logic [31:0] ALUResult, ALUResult4;
  logic        Zero, Zero4, stall, stall4;

  int checks = 0;
  int errors = 0;

  logic [3:0]  rc;
  logic [31:0] ra, rb;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .MUL_STEP(1)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .hold(hold),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
    .ALUResult(ALUResult), .Zero(Zero), .stall(stall)
  );

  alu_exec_unit #(.XLEN(32), .MUL_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .en(en4), .flush(flush), .hold(hold),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
    .ALUResult(ALUResult4), .Zero(Zero4), .stall(stall4)
  );

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic        en;
    logic        flush;
    logic [31:0] expRes;
    logic        expStall;
  } vector_t;

  vector_t vecs[$];

  // Reference ALU computed from the arithmetic rules using wide integers.
  function automatic logic [31:0] refAlu(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    int unsigned sh = b[4:0];
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint wide;
    case (c)
      ALU_ADD:  wide = ua + ub;
      ALU_SUB:  wide = ua - ub;
      ALU_AND:  wide = ua & ub;
      ALU_OR:   wide = ua | ub;
      ALU_XOR:  wide = ua ^ ub;
      ALU_SLT:  wide = (sa < sb) ? 64'd1 : 64'd0;
      ALU_SLL:  wide = ua << sh;
      ALU_SRL:  wide = ua >> sh;
      ALU_SRA:  wide = sa >>> sh;
      ALU_SLTU: wide = (ua < ub) ? 64'd1 : 64'd0;
      ALU_MUL:  wide = ua * ub;
      default:  wide = 0;
    endcase
    return wide[31:0];
  endfunction

  task automatic applyStimulus(input int sel, input logic [3:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic e, input logic f,
                               input logic h);
    ALUControl = c;
    SrcA       = a;
    SrcB       = b;
    en         = (sel == 0) ? e : 1'b0;
    en4        = (sel == 1) ? e : 1'b0;
    flush      = f;
    hold       = h;
  endtask

  task automatic checkOutput(input int sel, input string name, input logic [31:0] expRes,
                             input logic expStall);
    logic [31:0] r;
    logic        z, s;
    r = (sel == 0) ? ALUResult : ALUResult4;
    z = (sel == 0) ? Zero : Zero4;
    s = (sel == 0) ? stall : stall4;
    checks++;
    if (r !== expRes || z !== (expRes == 32'd0) || s !== expStall) begin
      errors++;
      $display("[TB] FAIL %s (dut%0d): got ALUResult=%h Zero=%b stall=%b, expected ALUResult=%h Zero=%b stall=%b",
               name, sel, r, z, s, expRes, (expRes == 32'd0), expStall);
    end
  endtask

  task automatic sampleEdge();
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Full multiply: stalled issue cycles, then the product held for holdCycles.
  task automatic runMul(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input int holdCycles, input string name);
    int          iters = (sel == 0) ? 32 : 8;
    logic [31:0] expProd = refAlu(ALU_MUL, a, b);
    applyStimulus(sel, ALU_MUL, a, b, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c <= iters; c++) begin
      sampleEdge();
      checkOutput(sel, {name, " busy"}, 32'd0, 1'b1);
      nextCycle();
    end
    for (int k = 0; k < holdCycles; k++) begin
      hold = 1'b1;
      sampleEdge();
      checkOutput(sel, {name, " held result"}, expProd, 1'b0);
      nextCycle();
    end
    hold = 1'b0;
    sampleEdge();
    checkOutput(sel, {name, " result"}, expProd, 1'b0);
    nextCycle();
  endtask

  task automatic singleOp(input int sel, input string name, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] expRes);
    applyStimulus(sel, c, a, b, 1'b1, 1'b0, 1'b0);
    sampleEdge();
    checkOutput(sel, name, expRes, 1'b0);
    nextCycle();
  endtask

  initial begin
    vecs.push_back('{"add",          ALU_ADD,  32'd5,        32'd7,        1'b1, 1'b0, 32'd12,       1'b0});
    vecs.push_back('{"sub zero",     ALU_SUB,  32'd9,        32'd9,        1'b1, 1'b0, 32'd0,        1'b0});
    vecs.push_back('{"sub wrap",     ALU_SUB,  32'd3,        32'd5,        1'b1, 1'b0, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{"sra",          ALU_SRA,  32'h80000000, 32'h24,       1'b1, 1'b0, 32'hF8000000, 1'b0});
    vecs.push_back('{"srl",          ALU_SRL,  32'h80000000, 32'h24,       1'b1, 1'b0, 32'h08000000, 1'b0});
    vecs.push_back('{"sll 31",       ALU_SLL,  32'd1,        32'd31,       1'b1, 1'b0, 32'h80000000, 1'b0});
    vecs.push_back('{"sll shamt5",   ALU_SLL,  32'd3,        32'h21,       1'b1, 1'b0, 32'd6,        1'b0});
    vecs.push_back('{"slt",          ALU_SLT,  32'd1,        32'hFFFFFFFF, 1'b1, 1'b0, 32'd0,        1'b0});
    vecs.push_back('{"slt neg",      ALU_SLT,  32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 32'd1,        1'b0});
    vecs.push_back('{"sltu",         ALU_SLTU, 32'd1,        32'hFFFFFFFF, 1'b1, 1'b0, 32'd1,        1'b0});
    vecs.push_back('{"and",          ALU_AND,  32'hF0F0FF00, 32'h0FF0F0F0, 1'b1, 1'b0, 32'h00F0F000, 1'b0});
    vecs.push_back('{"or",           ALU_OR,   32'hF0F0FF00, 32'h0FF0F0F0, 1'b1, 1'b0, 32'hFFF0FFF0, 1'b0});
    vecs.push_back('{"xor",          ALU_XOR,  32'hF0F0FF00, 32'h0FF0F0F0, 1'b1, 1'b0, 32'hFF000FF0, 1'b0});
    vecs.push_back('{"unused 1101",  4'b1101,  32'h1234,     32'h5678,     1'b1, 1'b0, 32'd0,        1'b0});
    vecs.push_back('{"unused 1111",  4'b1111,  32'h1234,     32'h5678,     1'b1, 1'b0, 32'd0,        1'b0});
    vecs.push_back('{"mul no en",    ALU_MUL,  32'd6,        32'd7,        1'b0, 1'b0, 32'd0,        1'b0});
    vecs.push_back('{"mul flushed",  ALU_MUL,  32'd6,        32'd7,        1'b1, 1'b1, 32'd0,        1'b0});
    vecs.push_back('{"add in flush", ALU_ADD,  32'd4,        32'd4,        1'b1, 1'b1, 32'd8,        1'b0});

    reset = 1'b1;
    applyStimulus(0, ALU_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sampleEdge();
    checkOutput(0, "after reset", 32'd12, 1'b0);
    checkOutput(1, "after reset", 32'd12, 1'b0);
    nextCycle();

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].en, vecs[i].flush, 1'b0);
      sampleEdge();
      checkOutput(0, vecs[i].name, vecs[i].expRes, vecs[i].expStall);
      nextCycle();
    end

    // Back-to-back multiplies, then one held in the done state for three cycles.
    runMul(0, 32'h00010003, 32'd5, 0, "mul directed");
    runMul(0, 32'hFFFFFFFD, 32'd7, 0, "mul negative");
    runMul(0, 32'h00010003, 32'd5, 3, "mul hold");
    singleOp(0, "add after hold", ALU_ADD, 32'd1, 32'd2, 32'd3);

    // Flush in cycle 10 of a multiply.
    applyStimulus(0, ALU_MUL, 32'h1234, 32'h5678, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      sampleEdge();
      checkOutput(0, "pre-flush busy", 32'd0, 1'b1);
      nextCycle();
    end
    flush = 1'b1;
    sampleEdge();
    checkOutput(0, "flush cycle", 32'd0, 1'b0);
    nextCycle();
    singleOp(0, "add after flush", ALU_ADD, 32'd3, 32'd4, 32'd7);
    runMul(0, 32'd123, 32'd456, 0, "mul after flush");

    // Reset in cycle 20 of a multiply.
    applyStimulus(0, ALU_MUL, 32'h1234, 32'h5678, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      sampleEdge();
      checkOutput(0, "pre-reset busy", 32'd0, 1'b1);
      nextCycle();
    end
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    singleOp(0, "add after reset", ALU_ADD, 32'd3, 32'd4, 32'd7);

    runMul(1, 32'h00010003, 32'd5, 0, "mul4 directed");
    runMul(1, 32'hFFFFFFFD, 32'd7, 2, "mul4 negative");
    singleOp(1, "mul4 add after", ALU_SUB, 32'd10, 32'd4, 32'd6);

    for (int i = 0; i < 40; i++) begin
      rc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) rc = ALU_MUL;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 40);
      if (rc == ALU_MUL) begin
        runMul(i % 2, ra, rb, $urandom_range(0, 2), "rand mul");
      end else begin
        singleOp(i % 2, "rand alu", rc, ra, rb, refAlu(rc, ra, rb));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit ALUControl code produced by the ALU decoder and returns ALUResult and Zero.
- Single-cycle operations (add, sub, logic, shifts, compares) are combinational and complete in the same cycle.
- mul (low XLEN bits of the product) runs on an iterative shift-add engine. The unit asserts stall to the hazard unit until the product is ready.
- Sits between the ID/EX pipeline register and the EX/MEM register.

Parameters:
XLEN, 32, operand/result width
MUL_STEP, 1, multiplier bits retired per cycle; must divide XLEN (1, 2, 4, 8 legal)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  valid instruction present in EX this cycle
flush  input  1  EX flush (branch mispredict/trap); aborts any multiply
hold  input  1  downstream stall; EX/MEM cannot accept a result this cycle
ALUControl  input  4  operation code from ALU decoder
SrcA  input  XLEN  operand A
SrcB  input  XLEN  operand B (register or immediate; shamt = SrcB[4:0])
ALUResult  output  XLEN  operation result
Zero  output  1  ALUResult == 0
stall  output  1  hold IF/ID/EX; EX inputs must stay stable while high

Behaviour:
ALUControl encodings:
- 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed), 0110 sll, 0111 srl, 1000 sra, 1001 sltu, 1010 mul.
- 1011-1111: ALUResult = 0.

Arithmetic rules:
- All arithmetic is mod 2^XLEN.
- slt/sltu return {XLEN-1 zeros, flag}.
- Shifts use SrcB[4:0] only.
- mul returns the low XLEN bits of SrcA*SrcB. This is identical for signed and unsigned operands, so no sign handling is needed.
- Zero is combinational from ALUResult in every state.

States: IDLE, MUL_BUSY, MUL_DONE.

IDLE:
- Non-mul op: ALUResult combinational from SrcA/SrcB; stall = 0.
- mul with en=1 and flush=0: stall = 1 this cycle. Latch SrcA to multiplicand and SrcB to multiplier, clear acc, clear count. Next state MUL_BUSY.
- mul with en=0 or flush=1: no start. stall = 0. ALUResult = 0.

MUL_BUSY:
- stall = 1.
- Each cycle:
  - acc += (multiplicand * multiplier[MUL_STEP-1:0]).
  - multiplicand <<= MUL_STEP; multiplier >>= MUL_STEP.
  - count += 1.
- After XLEN/MUL_STEP iterations, go to MUL_DONE.
- ALUResult during MUL_BUSY = 0 (don't-care to the pipeline, but fixed for verification).

MUL_DONE:
- stall = 0; ALUResult = acc.
- hold=1: remain in MUL_DONE, holding acc and stall=0.
- hold=0: go to IDLE next cycle.

Latency and stall counts:
- mul presented in cycle 0 gives its result in cycle XLEN/MUL_STEP + 1.
- stall is high for XLEN/MUL_STEP + 1 cycles (33 at defaults).

flush:
- Has priority over all transitions except reset.
- From any state, next state is IDLE and acc/count are cleared.
- stall is driven 0 combinationally in the flush cycle so the front end can redirect.

Back-to-back mul:
- After MUL_DONE, the unit returns to IDLE.
- The next mul in EX starts a fresh sequence with no extra bubble beyond its own latency.

reset:
- Next state IDLE; multiplicand, multiplier, acc and count cleared to 0.
- Applies mid-multiply with the same effect.
- After reset, outputs follow the IDLE rules, so stall = 0 unless a mul is presented with en=1.

Decomposition:
- alu_pkg holds:
  - ALUControl localparams (ALU_ADD ... ALU_MUL), shared with the ALU decoder.
  - The state enum {IDLE, MUL_BUSY, MUL_DONE}.
  - The XLEN default.
- Sub-module mul_iter, parameters XLEN and MUL_STEP:
  - Inputs: start, abort.
  - Contains the shift-add datapath and iteration counter.
  - Outputs: done pulse and product.
- alu_exec_unit keeps the combinational ALU, the state machine, and the stall/hold/flush logic.

Test Plan:
- add 5+7 -> ALUResult=12, Zero=0, stall=0 same cycle. sub 9-9 -> ALUResult=0, Zero=1.
- sra SrcA=0x80000000, SrcB=0x24 (shamt 4) -> 0xF8000000. srl same operands -> 0x08000000. sll 1 by 31 -> 0x80000000.
- slt SrcA=1, SrcB=0xFFFFFFFF -> 0. sltu same operands -> 1. Unused code 1101 -> 0.
- mul 0x00010003 * 0x00000005, MUL_STEP=1:
  - stall high cycles 0..32, low cycle 33.
  - ALUResult = 0x0005000F in cycle 33.
  - mul 0xFFFFFFFD * 7 -> 0xFFFFFFEB.
- mul with hold=1 for 3 cycles in MUL_DONE -> ALUResult stays 0x0005000F and stall=0 throughout; state returns to IDLE the cycle after hold drops.
- Abort cases:
  - flush asserted in cycle 10 of a mul -> stall=0 in cycle 10, IDLE in cycle 11.
  - reset in cycle 20 -> IDLE, stall=0 for a subsequent add.
  - Repeat the full mul directed test with MUL_STEP=4 -> result in cycle 9.
